mesi_snoop_bus: RTL
===================

// Module: mesi_snoop_bus
// PURPOSE
//  Shared snoop-bus arbiter/sequencer below the two MESI cache controllers in cache_top.
//  Accepts bus transactions (BusRd/BusRdX/BusUpgr/BusWB) from either cache and grants one at a time, round-robin.
//  Broadcasts each granted request to the other cache and collects its hit/dirty response.
//  Runs any flush and fill against memory, then signals completion with the shared indication.
// PARAMETERS
//  ADDR_W  8  line address width, matches cpu_addr
// PORTS
//  clk          in   1       clock, all logic on posedge
//  rst          in   1       synchronous, active-low reset
//  req[2]       in   1 each  bus request per cache; level, held until gnt
//  req_cmd[2]   in   2 each  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 BusWB
//  req_addr[2]  in   ADDR_W  request line address per cache
//  gnt[2]       out  1 each  one-cycle grant pulse; cmd/addr latched on it
//  done[2]      out  1 each  one-cycle completion pulse to owner
//  shared_out   out  1       valid with done: other cache kept a copy (owner fills S, not E)
//  snoop_valid[2] out 1 each one-cycle snoop strobe to the non-owner cache
//  snoop_cmd    out  2       latched command, valid with snoop_valid
//  snoop_addr   out  ADDR_W  latched address, valid with snoop_valid
//  snoop_hit[2] in   1 each  non-owner holds line (S/E/M); sampled at end of SNOOP
//  snoop_dirty[2] in 1 each  non-owner holds line in M; must flush
//  mem_req      out  1       memory request, held until mem_ack
//  mem_we       out  1       1 = write (flush/BusWB), 0 = fill read
//  mem_addr     out  ADDR_W  latched address
//  mem_ack      in   1       memory completion; ignored outside FLUSH/MEM
//  protocol_err out  1       sticky: snoop_dirty seen without snoop_hit
// BEHAVIOUR
//  Reset (rst=0 at posedge): state IDLE; all outputs 0; rr pointer = 1 (core 0 wins first tie).
//  Reset mid-transaction aborts it: next cycle IDLE, mem_req/snoop_valid 0, latched request dropped.
//  FSM IDLE -> GRANT -> SNOOP -> [FLUSH] -> [MEM] -> DONE -> IDLE.
//  IDLE: any req sampled -> GRANT. Both -> core != rr pointer; pointer := granted core at GRANT.
//  GRANT (1 cyc): gnt[owner]=1; latch owner, cmd, addr. BusWB -> MEM; else -> SNOOP.
//  SNOOP (1 cyc): snoop_valid[other]=1; snoop_hit/dirty[other] registered at exit.
//   dirty -> FLUSH; else BusRd/BusRdX -> MEM; BusUpgr -> DONE.
//  FLUSH: mem_req=1, mem_we=1 until mem_ack sampled; BusRd/BusRdX -> MEM.
//  MEM: mem_req=1, mem_we=(cmd==BusWB); exit on sampled mem_ack -> DONE.
//  DONE (1 cyc): done[owner]=1; shared_out = hit & (cmd==BusRd); else 0. -> IDLE.
//  Min latency req-sample edge to done: BusUpgr 3 cyc; BusRd clean, mem_ack tied 1: 4 cyc.
//  mem_ack same cycle as mem_req entry completes in 1 cyc; no timeout.
//  One transaction in flight; other core's req is held off, never lost or queued twice.
//  Owner dropping req after gnt has no effect; req re-asserted in DONE waits for next IDLE.
//  Outputs registered from state; snoop_addr/mem_addr stable entire transaction.
//  snoop_dirty & !snoop_hit: protocol_err=1 until reset; treated as dirty (flush).
// TESTING
//  Reset: rst=0 3 cyc, all req=1 -> gnt/done/mem_req/snoop_valid all 0; first tie after release -> gnt[0].
//  Tie: both BusRd (0xAA, 0x55) -> gnt[0], done[0], then gnt[1]; next tie -> gnt[0].
//  Dirty snoop: core0 BusRd 0xAA, hit[1]=dirty[1]=1 -> mem_we=1 @0xAA, fill mem_we=0, done[0] shared_out=1.
//  Upgrade: core1 BusUpgr 0x10 -> snoop_valid[0], snoop_cmd=10, no mem_req, done[1] 3 cyc after req.
//  Writeback: core0 BusWB 0x3C -> no snoop_valid, mem_req mem_we=1 @0x3C, done[0] shared_out=0.
//  Abort/error: rst=0 while MEM waits -> IDLE next cyc, mem_req=0; dirty without hit -> protocol_err sticky.

Source files
------------

// File: rtl/mesi_snoop_bus.sv
// mesi_snoop_bus: shared snoop-bus arbiter/sequencer below the two MESI cache
// controllers. Grants one bus transaction at a time (round-robin on ties),
// broadcasts it to the other cache, runs any flush and fill against memory,
// then pulses done to the owner together with the shared indication.
//
// Ports (index 0/1 = cache 0/1; packed per-core fields, core 1 in the upper half):
//   clk_i             clock, all logic on posedge
//   rst_ni            synchronous active-low reset
//   req_i[1:0]        level bus request per cache, held until gnt
//   req_cmd_i[3:0]    2-bit command per cache: 00 BusRd, 01 BusRdX, 10 BusUpgr, 11 BusWB
//   req_addr_i        ADDR_W-bit line address per cache
//   gnt_o[1:0]        one-cycle grant pulse; cmd/addr latched at its end
//   done_o[1:0]       one-cycle completion pulse to owner
//   shared_out_o      with done: other cache kept a copy
//   snoop_valid_o     one-cycle snoop strobe to the non-owner
//   snoop_cmd_o       latched command
//   snoop_addr_o      latched address
//   snoop_hit_i       non-owner holds the line
//   snoop_dirty_i     non-owner holds the line modified
//   mem_req_o         memory request, held until mem_ack_i
//   mem_we_o          1 = write (flush/BusWB), 0 = fill read
//   mem_addr_o        latched address
//   mem_ack_i         memory completion
//   protocol_err_o    sticky: dirty reported without hit
module mesi_snoop_bus #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            req_i,
  input  logic [3:0]            req_cmd_i,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            done_o,
  output logic                  shared_out_o,
  output logic [1:0]            snoop_valid_o,
  output logic [1:0]            snoop_cmd_o,
  output logic [ADDR_W-1:0]     snoop_addr_o,
  input  logic [1:0]            snoop_hit_i,
  input  logic [1:0]            snoop_dirty_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic                  mem_ack_i,
  output logic                  protocol_err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_SNOOP, S_FLUSH, S_MEM, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    BUS_RD = 2'b00, BUS_RDX = 2'b01, BUS_UPGR = 2'b10, BUS_WB = 2'b11
  } cmd_e;

  state_e              state_q, state_d;
  cmd_e                cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                owner_q, owner_d;
  logic                rr_q, rr_d;
  logic                hit_q, hit_d;
  logic                dirty_q, dirty_d;
  logic                perr_q, perr_d;
  logic                other;

  assign other          = ~owner_q;
  assign snoop_cmd_o    = cmd_q;
  assign snoop_addr_o   = addr_q;
  assign mem_addr_o     = addr_q;
  assign protocol_err_o = perr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cmd_q   <= BUS_RD;
      addr_q  <= '0;
      owner_q <= 1'b0;
      rr_q    <= 1'b1;
      hit_q   <= 1'b0;
      dirty_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hit_q   <= hit_d;
      dirty_q <= dirty_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    hit_d         = hit_q;
    dirty_d       = dirty_q;
    perr_d        = perr_q;
    gnt_o         = '0;
    done_o        = '0;
    shared_out_o  = 1'b0;
    snoop_valid_o = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          // On a tie the core that did not win last time goes first.
          owner_d = (req_i == 2'b11) ? ~rr_q : req_i[1];
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        gnt_o[owner_q] = 1'b1;
        rr_d    = owner_q;
        cmd_d   = cmd_e'(owner_q ? req_cmd_i[3:2] : req_cmd_i[1:0]);
        addr_d  = owner_q ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
        hit_d   = 1'b0;
        dirty_d = 1'b0;
        state_d = (cmd_d == BUS_WB) ? S_MEM : S_SNOOP;
      end
      S_SNOOP: begin
        snoop_valid_o[other] = 1'b1;
        hit_d   = snoop_hit_i[other];
        dirty_d = snoop_dirty_i[other];
        // Dirty without hit is flagged but still flushed, so data is never lost.
        if (snoop_dirty_i[other] && !snoop_hit_i[other]) perr_d = 1'b1;
        if (snoop_dirty_i[other])   state_d = S_FLUSH;
        else if (cmd_q == BUS_UPGR) state_d = S_DONE;
        else                        state_d = S_MEM;
      end
      S_FLUSH: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_ack_i) state_d = (cmd_q == BUS_UPGR) ? S_DONE : S_MEM;
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (cmd_q == BUS_WB);
        if (mem_ack_i) state_d = S_DONE;
      end
      S_DONE: begin
        done_o[owner_q] = 1'b1;
        shared_out_o    = hit_q && (cmd_q == BUS_RD);
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
